// File: rtl/result_display_driver.sv
// Display stage: double-dabble BCD conversion of the adder sum and
// multiplexed 7-segment scan with leading-zero blanking.
module result_display_driver #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       busy,
  output logic [6:0] seg,
  output logic [2:0] dig_sel
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

  state_t      state;
  logic [7:0]  sh;
  logic [11:0] bcd;
  logic [2:0]  cnt;
  logic [3:0]  hund, tens, ones;
  logic [15:0] scan_cnt;
  logic [1:0]  dig_idx;

  logic [11:0] bcd_adj;
  logic [19:0] shifted;
  logic [3:0]  cur_val;
  logic [2:0]  cur_sel;
  logic        cur_blank;

  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  assign load_ready = (state == IDLE);
  assign busy       = (state == CONV);

  always_comb begin
    bcd_adj = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};
    shifted = {bcd_adj, sh} << 1;
  end

  // Index 3 is unreachable; it falls back to the ones digit.
  always_comb begin
    cur_val   = ones;
    cur_sel   = 3'b001;
    cur_blank = 1'b0;
    unique case (dig_idx)
      2'd1: begin
        cur_val   = tens;
        cur_sel   = 3'b010;
        cur_blank = (hund == 4'd0) && (tens == 4'd0);
      end
      2'd2: begin
        cur_val   = hund;
        cur_sel   = 3'b100;
        cur_blank = (hund == 4'd0);
      end
      default: begin
        cur_val   = ones;
        cur_sel   = 3'b001;
        cur_blank = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      hund     <= '0;
      tens     <= '0;
      ones     <= '0;
      scan_cnt <= '0;
      dig_idx  <= '0;
      seg      <= '0;
      dig_sel  <= '0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            sh    <= load_data;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          sh  <= shifted[7:0];
          bcd <= shifted[19:8];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            hund  <= shifted[19:16];
            tens  <= shifted[15:12];
            ones  <= shifted[11:8];
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (scan_cnt == LAST) begin
        scan_cnt <= '0;
        dig_idx  <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end

      dig_sel <= cur_sel;
      seg     <= cur_blank ? 7'h00 : seg7(cur_val);
    end
  end

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver with a short scan period.
module tb_result_display_driver;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'd0;
  logic       load_ready, busy;
  logic [6:0] seg;
  logic [2:0] dig_sel;

  int tests = 0;
  int fails = 0;

  result_display_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .busy(busy),
    .seg(seg), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Waits for each digit slot and checks its pattern.
  task automatic check_digits(input string tag, input logic [6:0] e_one,
                              input logic [6:0] e_ten,
                              input logic [6:0] e_hun);
    logic [2:0] sel;
    logic [6:0] e;
    logic found;
    tick();
    for (int d = 0; d < 3; d++) begin
      sel = 3'b001 << d;
      e = (d == 0) ? e_one : (d == 1) ? e_ten : e_hun;
      found = 1'b0;
      for (int i = 0; i < 4 * SD && !found; i++) begin
        if (dig_sel == sel) found = 1'b1;
        else tick();
      end
      chk({tag, "_slot"}, {7'd0, found}, 8'd1);
      chk({tag, "_seg"}, {1'b0, seg}, {1'b0, e});
    end
  endtask

  task automatic convert(input string tag, input logic [7:0] v,
                         output int n);
    load_valid = 1'b1;
    load_data = v;
    tick();
    load_valid = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_busy_len"}, 8'(n), 8'd8);
  endtask

  initial begin
    int n;
    logic [2:0] s_sel;
    logic [6:0] s_seg;

    // Reset with a pending handshake that must be ignored
    load_valid = 1'b1;
    load_data = 8'd77;
    tick();
    tick();
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ready", {7'd0, load_ready}, 8'd1);
    chk("rst_seg", {1'b0, seg}, 8'h00);
    chk("rst_sel", {5'd0, dig_sel}, 8'h00);
    load_valid = 1'b0;
    rst = 1'b0;

    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("idle_sel", {5'd0, dig_sel}, 8'(1 << (((k - 1) / SD) % 3)));
      chk("idle_seg", {1'b0, seg},
          ((((k - 1) / SD) % 3) == 0) ? 8'h3F : 8'h00);
      chk("idle_ready", {7'd0, load_ready}, 8'd1);
    end

    convert("v30", 8'd30, n);
    check_digits("v30", 7'h3F, 7'h4F, 7'h00);
    convert("v255", 8'd255, n);
    check_digits("v255", 7'h6D, 7'h6D, 7'h5B);
    convert("v105", 8'd105, n);
    check_digits("v105", 7'h6D, 7'h3F, 7'h06);
    convert("v5", 8'd5, n);
    check_digits("v5", 7'h6D, 7'h00, 7'h00);

    // Abort a conversion of 200 by reset at T+4
    convert("pre", 8'd128, n);
    load_valid = 1'b1;
    load_data = 8'd200;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ready", {7'd0, load_ready}, 8'd1);
    chk("mid_busy2", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("mid_idle", {7'd0, load_ready}, 8'd1);
    check_digits("mid", 7'h3F, 7'h00, 7'h00);

    // Back-to-back with held valid; data changes mid-conversion
    load_valid = 1'b1;
    load_data = 8'd7;
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) load_data = 8'd9;
      tick();
      chk("b2b_ready", {7'd0, load_ready}, (i == 8) ? 8'd1 : 8'd0);
      chk("b2b_busy", {7'd0, busy}, (i == 8) ? 8'd0 : 8'd1);
    end
    tick();
    load_valid = 1'b0;
    chk("b2b_acc2", {7'd0, busy}, 8'd1);
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("b2b_len", 8'(n), 8'd8);
    check_digits("b2b", 7'h6F, 7'h00, 7'h00);

    convert("v0", 8'd0, n);
    check_digits("v0", 7'h3F, 7'h00, 7'h00);

    // Freeze while idle: nothing moves and no handshake is taken
    s_sel = dig_sel;
    s_seg = seg;
    ena = 1'b0;
    load_valid = 1'b1;
    load_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_i_sel", {5'd0, dig_sel}, {5'd0, s_sel});
      chk("frz_i_seg", {1'b0, seg}, {1'b0, s_seg});
      chk("frz_i_busy", {7'd0, busy}, 8'd0);
    end
    load_valid = 1'b0;
    ena = 1'b1;

    // Freeze for 5 cycles during conversion of 128
    load_valid = 1'b1;
    load_data = 8'd128;
    tick();
    load_valid = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      if (n == 2) begin
        ena = 1'b0;
        s_sel = dig_sel;
        s_seg = seg;
      end
      if (n == 7) ena = 1'b1;
      tick();
      n++;
      if (n >= 3 && n <= 7) begin
        chk("frz_c_sel", {5'd0, dig_sel}, {5'd0, s_sel});
        chk("frz_c_seg", {1'b0, seg}, {1'b0, s_seg});
      end
    end
    ena = 1'b1;
    chk("frz_c_len", 8'(n), 8'd13);
    check_digits("v128", 7'h7F, 7'h5B, 7'h06);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
